// File: rtl/mips_boot_loader_pkg.sv
// Shared constants and state encoding for the MIPS boot loader.
// Module parameters default to these values.
package mips_boot_loader_pkg;

    localparam int          BOOT_ADDR_W    = 10;
    localparam int          BOOT_MAX_WORDS = 1024;
    localparam logic [7:0]  BOOT_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

endpackage

// File: rtl/mips_boot_loader_if.sv
// Byte-stream input, control and memory-write bundle of the boot loader.
// The slave modport is the loader, the master modport is its environment.
interface mips_boot_loader_if
    import mips_boot_loader_pkg::*;
#(
    parameter int ADDR_W = BOOT_ADDR_W
) ();

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              clear;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_hold;
    logic              load_done;
    logic              load_error;

    modport master (
        output in_valid, in_data, clear,
        input  in_ready, mem_we, mem_addr, mem_wdata, core_hold, load_done, load_error
    );

    modport slave (
        input  in_valid, in_data, clear,
        output in_ready, mem_we, mem_addr, mem_wdata, core_hold, load_done, load_error
    );

endinterface

// File: rtl/mips_boot_loader_packer.sv
// Packs accepted data bytes into big-endian 32-bit words.
// word/word_valid are registered; word holds its value between strobes.
module boot_word_packer (
    input  logic        clk1,
    input  logic        reset,
    input  logic        flush,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_last,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt;
    logic [23:0] shift_q;

    assign word_last = (byte_cnt == 2'd3);

    always_ff @(posedge clk1) begin
        if (reset) begin
            byte_cnt   <= 2'd0;
            shift_q    <= 24'd0;
            word_valid <= 1'b0;
            word       <= 32'd0;
        end else begin
            word_valid <= 1'b0;
            if (flush) begin
                byte_cnt <= 2'd0;
            end else if (byte_valid) begin
                shift_q  <= {shift_q[15:0], byte_in};
                byte_cnt <= byte_cnt + 2'd1;
                // the fourth byte completes the word; older bytes sit in shift_q
                if (word_last) begin
                    word       <= {shift_q, byte_in};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mips_boot_loader.sv
// Boot loader: receives a framed byte image, writes it word by word into
// main memory, verifies an XOR checksum and releases the MIPS core on success.
//
//   state     | meaning
//   ----------+----------------------------------------------
//   IDLE      | hunting for the sync byte
//   LEN_HI    | expecting high byte of word count
//   LEN_LO    | expecting low byte of word count, range check
//   DATA      | receiving 4*N data bytes, writing words
//   CHECK     | expecting checksum byte
//   DONE      | image good, core released, waits for clear
//   ERROR     | frame rejected, waits for clear
module mips_boot_loader
    import mips_boot_loader_pkg::*;
#(
    parameter int         ADDR_W    = BOOT_ADDR_W,
    parameter int         MAX_WORDS = BOOT_MAX_WORDS,
    parameter logic [7:0] SYNC_BYTE = BOOT_SYNC_BYTE
) (
    input  logic          clk1,
    input  logic          reset,
    mips_boot_loader_if.slave bus
);

    state_t            state_q;
    state_t            state_n;
    logic              in_ready_q;
    logic [7:0]        len_hi_q;
    logic [15:0]       len_q;
    logic [15:0]       len_rx;
    logic              len_ok;
    logic [15:0]       word_idx_q;
    logic              last_word;
    logic [7:0]        chk_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              xfer;
    logic              data_xfer;
    logic              word_last;
    logic              word_valid;
    logic [31:0]       word;

    assign xfer      = bus.in_valid && in_ready_q;
    assign data_xfer = xfer && !bus.clear && (state_q == ST_DATA);
    assign len_rx    = {len_hi_q, bus.in_data};
    assign len_ok    = (len_rx != 16'd0) && (32'(len_rx) <= MAX_WORDS);
    assign last_word = ((word_idx_q + 16'd1) == len_q);

    boot_word_packer u_packer (
        .clk1       (clk1),
        .reset      (reset),
        .flush      (bus.clear),
        .byte_valid (data_xfer),
        .byte_in    (bus.in_data),
        .word_last  (word_last),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk1) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // clear outranks any byte arriving in the same cycle
    always_comb begin
        state_n = state_q;
        if (bus.clear) begin
            state_n = ST_IDLE;
        end else if (xfer) begin
            case (state_q)
                ST_IDLE:   if (bus.in_data == SYNC_BYTE) state_n = ST_LEN_HI;
                ST_LEN_HI: state_n = ST_LEN_LO;
                ST_LEN_LO: state_n = len_ok ? ST_DATA : ST_ERROR;
                ST_DATA:   if (word_last && last_word) state_n = ST_CHECK;
                ST_CHECK:  state_n = (bus.in_data == chk_q) ? ST_DONE : ST_ERROR;
                default:   state_n = state_q;
            endcase
        end
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            in_ready_q <= 1'b1;
            len_hi_q   <= 8'd0;
            len_q      <= 16'd0;
            word_idx_q <= 16'd0;
            chk_q      <= 8'd0;
            mem_addr_q <= '0;
        end else begin
            in_ready_q <= (state_n != ST_DONE) && (state_n != ST_ERROR);
            if (bus.clear) begin
                word_idx_q <= 16'd0;
                chk_q      <= 8'd0;
            end else if (xfer) begin
                case (state_q)
                    ST_IDLE: begin
                        word_idx_q <= 16'd0;
                        chk_q      <= 8'd0;
                    end
                    ST_LEN_HI: len_hi_q <= bus.in_data;
                    ST_LEN_LO: len_q    <= len_rx;
                    ST_DATA: begin
                        chk_q <= chk_q ^ bus.in_data;
                        // address is latched alongside the word so both appear with the strobe
                        if (word_last) begin
                            mem_addr_q <= word_idx_q[ADDR_W-1:0];
                            word_idx_q <= word_idx_q + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.mem_we     = word_valid;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = word;
    assign bus.load_done  = (state_q == ST_DONE);
    assign bus.load_error = (state_q == ST_ERROR);
    assign bus.core_hold  = (state_q != ST_DONE);

endmodule

// File: tb/tb_mips_boot_loader.sv
// Bench for mips_boot_loader: byte-level frame model checked every cycle,
// directed frames with literal expectations, then randomized frames.
module tb_mips_boot_loader;

    logic clk1 = 1'b0;
    logic reset = 1'b1;

    always #5 clk1 = ~clk1;

    mips_boot_loader_if #(.ADDR_W(10)) bus ();

    mips_boot_loader #(
        .ADDR_W    (10),
        .MAX_WORDS (1024),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk1  (clk1),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int wr_count = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // frame model: phase 0 hunt, 1 len hi, 2 len lo, 3 data, 4 chk, 5 done, 6 error
    int          m_phase = 0;
    int          m_n     = 0;
    int          m_got   = 0;
    logic [7:0]  m_hi    = 8'd0;
    logic [7:0]  m_xor   = 8'd0;
    logic [31:0] m_word  = 32'd0;
    logic        m_we    = 1'b0;
    logic [9:0]  m_addr  = 10'd0;
    logic [31:0] m_data  = 32'd0;
    bit          started = 1'b0;

    always @(posedge clk1) begin
        logic       ready;
        logic [7:0] b;
        ready = !(m_phase == 5 || m_phase == 6);
        b     = bus.in_data;
        if (reset) begin
            m_phase = 0; m_we = 1'b0; m_addr = 10'd0; m_data = 32'd0;
            m_got = 0; m_xor = 8'd0; started = 1'b1;
        end else begin
            m_we = 1'b0;
            if (bus.clear) begin
                m_phase = 0;
            end else if (bus.in_valid && ready) begin
                case (m_phase)
                    0: if (b == 8'hA5) m_phase = 1;
                    1: begin m_hi = b; m_phase = 2; end
                    2: begin
                        m_n = 32'({m_hi, b});
                        m_got = 0; m_xor = 8'd0;
                        m_phase = (m_n >= 1 && m_n <= 1024) ? 3 : 6;
                    end
                    3: begin
                        m_xor  = m_xor ^ b;
                        m_word = {m_word[23:0], b};
                        m_got++;
                        if (m_got % 4 == 0) begin
                            m_we = 1'b1;
                            m_addr = 10'(m_got / 4 - 1);
                            m_data = m_word;
                        end
                        if (m_got == 4 * m_n) m_phase = 4;
                    end
                    4: m_phase = (b == m_xor) ? 5 : 6;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk1) begin
        if (started) begin
            if (bus.mem_we === 1'b1) wr_count++;
            check1 ("in_ready",   bus.in_ready,   !(m_phase == 5 || m_phase == 6));
            check1 ("load_done",  bus.load_done,  m_phase == 5);
            check1 ("load_error", bus.load_error, m_phase == 6);
            check1 ("core_hold",  bus.core_hold,  m_phase != 5);
            check1 ("mem_we",     bus.mem_we,     m_we);
            check32("mem_addr",   32'(bus.mem_addr), 32'(m_addr));
            check32("mem_wdata",  bus.mem_wdata,  m_data);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int k);
        repeat (k) @(negedge clk1);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        repeat (gap) @(negedge clk1);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(negedge clk1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_list(input logic [7:0] q[$], input int gap);
        foreach (q[i]) send(q[i], gap);
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        @(negedge clk1);
        bus.clear = 1'b0;
    endtask

    task automatic rand_frame();
        int         n, mode, k, maxgap, len;
        logic [7:0] x, b;
        n      = $urandom_range(1, 6);
        mode   = $urandom_range(0, 5);
        maxgap = $urandom_range(0, 2);
        x      = 8'd0;
        repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h00;
            send(b, $urandom_range(0, maxgap));
        end
        send(8'hA5, $urandom_range(0, maxgap));
        if (mode == 1) begin
            len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1025, 65535);
            send(8'(len >> 8), 0);
            send(8'(len), 0);
        end else begin
            send(8'(n >> 8), $urandom_range(0, maxgap));
            send(8'(n), $urandom_range(0, maxgap));
            k = (mode == 2) ? $urandom_range(0, 4 * n - 1) : 4 * n;
            for (int i = 0; i < k; i++) begin
                b = 8'($urandom);
                x = x ^ b;
                send(b, $urandom_range(0, maxgap));
            end
            if (mode == 2) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_data  = 8'($urandom);
                do_clear();
                bus.in_valid = 1'b0;
            end else begin
                send((mode == 0) ? (x ^ 8'h5A) : x, $urandom_range(0, maxgap));
            end
        end
        idle(3);
        do_clear();
        idle(1);
    endtask

    initial begin
        logic [7:0] q[$];
        int w0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        bus.clear    = 1'b0;
        reset        = 1'b1;
        idle(3);
        check1 ("rst_in_ready",  bus.in_ready, 1'b1);
        check1 ("rst_core_hold", bus.core_hold, 1'b1);
        check32("rst_mem_wdata", bus.mem_wdata, 32'h0);
        reset = 1'b0;
        idle(1);

        // single word frame with leading junk byte
        w0 = wr_count;
        q = {8'h00, 8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        send_list(q, 0);
        idle(2);
        check32("t1_writes",    32'(wr_count - w0), 32'd1);
        check32("t1_wdata",     bus.mem_wdata, 32'hDEADBEEF);
        check32("t1_addr",      32'(bus.mem_addr), 32'd0);
        check1 ("t1_load_done", bus.load_done, 1'b1);
        check1 ("t1_core_hold", bus.core_hold, 1'b0);
        do_clear();
        idle(1);

        // two words, valid toggling every other cycle
        w0 = wr_count;
        q = {8'hA5, 8'h00, 8'h02};
        send_list(q, 0);
        q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
        send_list(q, 1);
        idle(2);
        check32("t2_writes",    32'(wr_count - w0), 32'd2);
        check32("t2_wdata",     bus.mem_wdata, 32'h05060708);
        check32("t2_addr",      32'(bus.mem_addr), 32'd1);
        check1 ("t2_load_done", bus.load_done, 1'b1);
        do_clear();
        idle(1);

        // bad checksum
        w0 = wr_count;
        q = {8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        send_list(q, 0);
        idle(2);
        check32("t3_writes",     32'(wr_count - w0), 32'd1);
        check32("t3_wdata",      bus.mem_wdata, 32'h11223344);
        check1 ("t3_load_error", bus.load_error, 1'b1);
        check1 ("t3_in_ready",   bus.in_ready, 1'b0);
        check1 ("t3_core_hold",  bus.core_hold, 1'b1);
        do_clear();
        idle(1);

        // length limits
        w0 = wr_count;
        q = {8'hA5, 8'h00, 8'h00};
        send_list(q, 0);
        idle(2);
        check1 ("t4_zero_error", bus.load_error, 1'b1);
        do_clear();
        idle(1);
        q = {8'hA5, 8'h04, 8'h01};
        send_list(q, 0);
        idle(2);
        check1 ("t4_big_error", bus.load_error, 1'b1);
        check32("t4_writes",    32'(wr_count - w0), 32'd0);
        do_clear();
        idle(1);

        // reset mid-frame then a fresh frame
        q = {8'hA5, 8'h00, 8'h02, 8'hAA, 8'hBB};
        send_list(q, 0);
        reset = 1'b1;
        idle(1);
        check1 ("t5_in_ready",  bus.in_ready, 1'b1);
        check1 ("t5_mem_we",    bus.mem_we, 1'b0);
        check1 ("t5_core_hold", bus.core_hold, 1'b1);
        check32("t5_wdata_rst", bus.mem_wdata, 32'h0);
        reset = 1'b0;
        w0 = wr_count;
        q = {8'hA5, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h30};
        send_list(q, 0);
        idle(2);
        check32("t5_writes",    32'(wr_count - w0), 32'd1);
        check32("t5_wdata",     bus.mem_wdata, 32'hCAFEBABE);
        check32("t5_addr",      32'(bus.mem_addr), 32'd0);
        check1 ("t5_load_done", bus.load_done, 1'b1);
        do_clear();
        idle(1);

        // clear collides with a data byte
        w0 = wr_count;
        q = {8'hA5, 8'h00, 8'h01, 8'h12, 8'h34};
        send_list(q, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h56;
        do_clear();
        bus.in_valid = 1'b0;
        q = {8'hA5, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        send_list(q, 0);
        idle(2);
        check32("t6_writes",    32'(wr_count - w0), 32'd1);
        check32("t6_wdata",     bus.mem_wdata, 32'h01020304);
        check1 ("t6_load_done", bus.load_done, 1'b1);
        do_clear();
        idle(1);

        for (int i = 0; i < 30; i++) rand_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_boot_loader.md
MIPS_BOOT_LOADER -- requirements
Module: mips_boot_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: word-address width of the shared main memory.
REQ-002 SHALL have parameter MAX_WORDS, default 1024: largest accepted image length in words.
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-004 clk1  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  byte-stream source has a byte.
REQ-007 in_data  input  8  byte payload.
REQ-008 in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid and in_ready are both high on a clk1 edge.
REQ-009 clear  input  1  returns loader from DONE or ERROR to IDLE.
REQ-010 mem_we  output  1  one-cycle word write strobe to main memory.
REQ-011 mem_addr  output  ADDR_W  word address of the write.
REQ-012 mem_wdata  output  32  instruction/data word written.
REQ-013 core_hold  output  1  holds the MIPS32 core halted while high.
REQ-014 load_done  output  1  image loaded and checksum good.
REQ-015 load_error  output  1  frame rejected.

Function
REQ-016 Frame, in order: SYNC_BYTE, LEN_HI, LEN_LO (16-bit word count N), 4*N data bytes, CHK byte.
REQ-017 States SHALL be IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR.
REQ-018 IDLE: accepted bytes other than SYNC_BYTE are discarded; SYNC_BYTE -> LEN_HI.
REQ-019 LEN_HI -> LEN_LO on transfer; LEN_LO -> DATA on transfer if 1 <= N <= MAX_WORDS, else -> ERROR.
REQ-020 Data words are big-endian: 1st byte -> [31:24], 4th byte -> [7:0].
REQ-021 mem_we SHALL pulse high exactly the cycle after the 4th byte of each word transfers, with mem_wdata = the assembled word and mem_addr = word index (0, 1, ..., N-1).
REQ-022 mem_addr and mem_wdata SHALL hold their last values when mem_we is low.
REQ-023 After the 4th byte of word N-1: -> CHECK.
REQ-024 Running checksum = XOR of all 4*N data bytes; header bytes excluded.
REQ-025 CHECK: on transfer, CHK equal to running checksum -> DONE, otherwise -> ERROR.
REQ-026 in_ready SHALL be high in IDLE, LEN_HI, LEN_LO, DATA and CHECK, and low in DONE and ERROR.
REQ-027 in_ready is a registered output; a cycle with in_valid low leaves all state unchanged (stalls are allowed anywhere in the frame).
REQ-028 load_done SHALL be high exactly while in DONE; load_error exactly while in ERROR.
REQ-029 core_hold SHALL be low only in DONE.
REQ-030 DONE and ERROR are sticky until clear; clear in DONE or ERROR -> IDLE next cycle, resetting the word index and checksum.
REQ-031 clear in any other state SHALL abort the frame -> IDLE; clear takes priority over a simultaneous transfer, and the transferred byte is dropped.
REQ-032 Words already written before an abort or ERROR are not rolled back.

Reset
REQ-033 reset SHALL have priority over clear and over any transfer.
REQ-034 On reset: state = IDLE, in_ready = 1, mem_we = 0, mem_addr = 0, mem_wdata = 0, load_done = 0, load_error = 0, core_hold = 1, word index = 0, byte counter = 0, checksum = 0.
REQ-035 reset mid-frame SHALL abandon the frame and issue no further write.

Structure
REQ-036 Shared package holds: SYNC_BYTE, state encoding, ADDR_W, and MAX_WORDS.
REQ-037 One sub-module, boot_word_packer: 2-bit byte counter plus 32-bit shift register, emitting word_valid and word. The FSM, address counter and checksum stay in mips_boot_loader.

Verification
REQ-038 Bytes 00,A5,00,01,DE,AD,BE,EF,chk=22 -> mem_we once, addr 0, wdata DEADBEEF; load_done=1; core_hold=0.
REQ-039 A5,00,02, then 8 bytes with in_valid toggled every other cycle, correct chk -> writes at addr 0 then addr 1; DONE.
REQ-040 A5,00,01,11,22,33,44,chk=00 (correct value 44) -> ERROR; load_error=1; in_ready=0; core_hold=1; the write to addr 0 still occurred.
REQ-041 A5,00,00 -> ERROR with no write; A5,04,01 (N=1025) -> ERROR with no write.
REQ-042 reset asserted after 2 data bytes -> all outputs at reset values the next cycle; a fresh frame then loads at addr 0.
REQ-043 clear asserted in the same cycle as a data-byte transfer mid-frame -> IDLE and byte dropped; a subsequent full frame loads correctly.
